fifo_wr_arbiter: RTL
====================

# fifo_wr_arbiter

Round-robin arbiter sharing the single write port of the synchronous FIFO among NUM_REQ requesters. A grantee keeps the port for up to MAX_BURST accepted beats, then ownership passes on. The block sits between the producer-side requesters and the FIFO's wr_en/data_in/full pins. It never issues a write while full is high.

## Interface
- DATA_WIDTH, 8, width of each requester's data and of FIFO data_in
- NUM_REQ, 4, number of requesters (≥2)
- MAX_BURST, 4, maximum consecutive beats per ownership (≥1)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  per-requester write request
- req_data  in  NUM_REQ*DATA_WIDTH  requester i at [i*DATA_WIDTH +: DATA_WIDTH]
- full  in  1  FIFO full flag
- gnt  out  NUM_REQ  one-hot (or zero) acceptance; beat i consumed at the edge where gnt[i]=1
- wr_en  out  1  FIFO write enable, equals |gnt
- data_in  out  DATA_WIDTH  FIFO write data; selected requester's slice when wr_en=1, else 0
- owner  out  $clog2(NUM_REQ)  registered current/last owner index
- busy  out  1  high in BURST state

## Operation
- State: fsm {IDLE, BURST}, rr_ptr (next priority index), owner, beat_cnt (width $clog2(MAX_BURST+1)).
- IDLE:
  - sel = first i with req[i]=1 searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - gnt[sel] = !full.
  - On an accepted beat with MAX_BURST>1: owner←sel, beat_cnt←1, go to BURST.
  - On an accepted beat with MAX_BURST=1: rr_ptr←sel+1 mod NUM_REQ, owner←sel, stay IDLE.
  - No req, or full=1: no grant, state unchanged.
- BURST:
  - gnt[owner] = req[owner] & !full. All other gnt bits are 0.
  - Accepted beat: beat_cnt+1.
    - If beat_cnt+1 == MAX_BURST: rr_ptr←owner+1 mod NUM_REQ, beat_cnt←0, go to IDLE.
  - full=1 with req[owner]=1: hold. No grant, beat_cnt unchanged, ownership kept.
  - req[owner]=0: release. No grant that cycle, rr_ptr←owner+1 mod NUM_REQ, beat_cnt←0, go to IDLE.
- Other requesters' req changes never affect an active burst.
- wr_en is never 1 while full=1.
- data_in is a pure mux of req_data by the granted index.
- rr_ptr wraps from NUM_REQ-1 to 0.

## Timing
- gnt, wr_en and data_in are combinational from req, req_data, full and registered state. Grant latency is zero cycles.
- Handshake: requester holds req and req_data stable until it sees gnt. A beat transfers at the clock edge where gnt=1.
- fsm, rr_ptr, owner and beat_cnt update on the rising clk edge.
- Release on req drop costs exactly one dead cycle.
- Release on burst completion costs no dead cycle. The next IDLE cycle may grant immediately.
- Reset (rst=1, any time, including mid-burst): asynchronously fsm=IDLE, rr_ptr=0, owner=0, beat_cnt=0, busy=0. While rst=1: gnt=0, wr_en=0, data_in=0.
- First edge after rst falls: normal IDLE arbitration from rr_ptr=0.

## Test plan
- Reset mid-burst: assert rst during a beat of owner 2.
  - Required: gnt=0, wr_en=0, data_in=0, busy=0, owner=0 immediately.
  - After release with req=4'b1111: first grant goes to 0.
- Full rotation: NUM_REQ=4, MAX_BURST=4, req=4'b1111, requester i drives 8'hA0+i, full=0.
  - Required: wr_en=1 every cycle.
  - Grant sequence is 0×4, 1×4, 2×4, 3×4, 0…
  - data_in matches A0/A1/A2/A3.
- Backpressure: in the same setup, full=1 for 3 cycles after requester 0's second beat.
  - Required: gnt=0 and wr_en=0 for those 3 cycles, owner stays 0.
  - Requester 0 then gets exactly 2 more beats before requester 1 is granted.
- Early release: requester 1 drops req after 2 beats, req=4'b1101.
  - Required: one cycle with wr_en=0.
  - Next grant goes to requester 2 (rr_ptr=2).
- Wrap-around: only req[3]=1, from reset.
  - Required: granted on the first cycle.
  - After 4 beats: rr_ptr=0, one idle transition, then requester 3 regranted.
- MAX_BURST=1: req=4'b0101.
  - Required: grants alternate 0, 2, 0, 2 every cycle, busy stays 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port; a grantee owns the port for up to MAX_BURST beats.
// Grants are combinational (zero latency); full=1 suppresses every grant and freezes the burst.
module fifo_wr_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic                          full,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         data_in,
  output logic [$clog2(NUM_REQ)-1:0]    owner,
  output logic                          busy
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_rr_ptr, w_rr_ptr_nxt;
  logic [IW-1:0]   r_owner, w_owner_nxt;
  logic [CW-1:0]   r_beat_cnt, w_beat_cnt_nxt;
  logic [CW-1:0]   w_cnt_inc;
  logic [IW-1:0]   w_sel;
  logic [IW-1:0]   w_gidx;
  logic            w_any;
  int              w_idx;

  function automatic logic [IW-1:0] f_inc(input logic [IW-1:0] i);
    if (int'(i) == NUM_REQ - 1) return '0;
    else                        return i + IW'(1);
  endfunction

  // Scan from lowest priority to highest so the last hit is the winner.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_idx = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
      if (req[w_idx]) begin
        w_any = 1'b1;
        w_sel = IW'(w_idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_rr_ptr   <= '0;
      r_owner    <= '0;
      r_beat_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_rr_ptr   <= w_rr_ptr_nxt;
      r_owner    <= w_owner_nxt;
      r_beat_cnt <= w_beat_cnt_nxt;
    end
  end

  assign w_cnt_inc = r_beat_cnt + CW'(1);

  always_comb begin
    w_state_nxt    = r_state;
    w_rr_ptr_nxt   = r_rr_ptr;
    w_owner_nxt    = r_owner;
    w_beat_cnt_nxt = r_beat_cnt;
    case (r_state)
      S_IDLE: begin
        if (wr_en) begin
          w_owner_nxt = w_sel;
          if (MAX_BURST > 1) begin
            w_state_nxt    = S_BURST;
            w_beat_cnt_nxt = CW'(1);
          end else begin
            w_rr_ptr_nxt = f_inc(w_sel);
          end
        end
      end
      S_BURST: begin
        if (wr_en) begin
          if (w_cnt_inc == CW'(MAX_BURST)) begin
            w_state_nxt    = S_IDLE;
            w_rr_ptr_nxt   = f_inc(r_owner);
            w_beat_cnt_nxt = '0;
          end else begin
            w_beat_cnt_nxt = w_cnt_inc;
          end
        end else if (!req[r_owner]) begin
          // Owner dropped its request: give up the port, costing this one dead cycle.
          w_state_nxt    = S_IDLE;
          w_rr_ptr_nxt   = f_inc(r_owner);
          w_beat_cnt_nxt = '0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gnt    = '0;
    w_gidx = r_owner;
    if (!rst) begin
      case (r_state)
        S_IDLE: begin
          w_gidx = w_sel;
          if (w_any && !full) gnt[w_sel] = 1'b1;
        end
        S_BURST: begin
          if (req[r_owner] && !full) gnt[r_owner] = 1'b1;
        end
        default: gnt = '0;
      endcase
    end
  end

  assign wr_en   = |gnt;
  assign data_in = wr_en ? req_data[w_gidx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign owner   = r_owner;
  assign busy    = (r_state == S_BURST);

endmodule
